// File: rtl/leaf_out_arbiter_pkg.sv
// Shared definitions for the leaf output arbiter: packet field offsets, FSM encoding, credit arithmetic.
package leaf_out_arbiter_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Packet layout, LSB first: payload | seq | dest_port | dest_leaf | valid
    function automatic int pkt_seq_lsb(input int payload_bits);
        return payload_bits;
    endfunction

    function automatic int pkt_dport_lsb(input int payload_bits, input int addr_bits);
        return payload_bits + addr_bits;
    endfunction

    function automatic int pkt_leaf_lsb(input int payload_bits, input int addr_bits, input int port_bits);
        return payload_bits + addr_bits + port_bits;
    endfunction

    function automatic int pkt_valid_bit(input int payload_bits, input int addr_bits,
                                         input int port_bits, input int leaf_bits);
        return payload_bits + addr_bits + port_bits + leaf_bits;
    endfunction

    // Credit after one cycle of optional return and optional send, clamped at cmax.
    function automatic int sat_credit(input int cur, input logic ret, input logic dec,
                                      input int quantum, input int cmax);
        int sum;
        sum = cur + (ret ? quantum : 0) - (dec ? 1 : 0);
        return (sum > cmax) ? cmax : sum;
    endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search begins at the requester after last_i and wraps.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    logic found;

    always_comb begin
        found     = 1'b0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req_i[j] && (j == (int'(last_i) + k) % N)) begin
                    found       = 1'b1;
                    gnt_oh_o[j] = 1'b1;
                    gnt_idx_o   = IW'(j);
                end
            end
        end
        gnt_vld_o = found;
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Merges NUM_OUT_PORTS credit-limited user streams into one registered BFT packet lane.
// One-cycle latency; a stalled lane (out_ready=0) freezes the held packet and withholds all acks.
module leaf_out_arbiter
    import leaf_out_arbiter_pkg::*;
#(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_OUT_PORTS         = 4,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int CREDIT_BITS           = 8,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user,
    output logic [NUM_OUT_PORTS-1:0]              ack_user,
    input  logic                                  cfg_wr,
    input  logic [NUM_PORT_BITS-1:0]              cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0]              cfg_dport,
    input  logic                                  credit_vld,
    input  logic [NUM_PORT_BITS-1:0]              credit_port,
    output logic [PACKET_BITS-1:0]                dout_pkt,
    input  logic                                  out_ready,
    output logic [NUM_PORT_BITS-1:0]              grant_port
);

    localparam int SEQ_LSB    = pkt_seq_lsb(PAYLOAD_BITS);
    localparam int DPORT_LSB  = pkt_dport_lsb(PAYLOAD_BITS, NUM_ADDR_BITS);
    localparam int LEAF_LSB   = pkt_leaf_lsb(PAYLOAD_BITS, NUM_ADDR_BITS, NUM_PORT_BITS);
    localparam int VALID_BIT  = pkt_valid_bit(PAYLOAD_BITS, NUM_ADDR_BITS, NUM_PORT_BITS, NUM_LEAF_BITS);
    localparam int CREDIT_MAX = (1 << CREDIT_BITS) - 1;

    state_e                   state_q, state_d;
    logic [NUM_OUT_PORTS-1:0] cfg_q, cfg_d;
    logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] leaf_d   [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dport_q  [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dport_d  [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_q    [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_d    [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] last_q, last_d, grant_q, grant_d;
    logic [PACKET_BITS-1:0]   pkt_q, pkt_d;

    logic [NUM_OUT_PORTS-1:0] eligible, gnt_oh, sent, returned;
    logic [NUM_PORT_BITS-1:0] gnt_idx;
    logic                     gnt_vld, can_load, fire;

    always_comb begin
        eligible = '0;
        returned = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = vld_user[i] && cfg_q[i] && (credit_q[i] != '0);
            returned[i] = credit_vld && cfg_q[i] && (credit_port == NUM_PORT_BITS'(i));
        end
    end

    rr_arbiter #(
        .N  (NUM_OUT_PORTS),
        .IW (NUM_PORT_BITS)
    ) u_rr (
        .req_i     (eligible),
        .last_i    (last_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign can_load = (state_q == ST_EMPTY) || out_ready;
    assign fire     = can_load && gnt_vld;
    assign sent     = fire ? gnt_oh : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (can_load) state_d = gnt_vld ? ST_FULL : ST_EMPTY;
    end

    always_comb begin
        ack_user   = sent;
        dout_pkt   = pkt_q;
        grant_port = grant_q;
    end

    always_comb begin
        pkt_d   = pkt_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (can_load) begin
            pkt_d = '0;
            if (gnt_vld) begin
                grant_d          = gnt_idx;
                last_d           = gnt_idx;
                pkt_d[VALID_BIT] = 1'b1;
                for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                    if (gnt_oh[i]) begin
                        pkt_d[LEAF_LSB +: NUM_LEAF_BITS]  = leaf_q[i];
                        pkt_d[DPORT_LSB +: NUM_PORT_BITS] = dport_q[i];
                        pkt_d[SEQ_LSB +: NUM_ADDR_BITS]   = seq_q[i];
                        pkt_d[0 +: PAYLOAD_BITS]          = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                    end
                end
            end
        end
    end

    // A configuration write wins over a same-cycle send or credit return on that port.
    always_comb begin
        cfg_d = cfg_q;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            leaf_d[i]   = leaf_q[i];
            dport_d[i]  = dport_q[i];
            seq_d[i]    = sent[i] ? seq_q[i] + 1'b1 : seq_q[i];
            credit_d[i] = CREDIT_BITS'(sat_credit(int'(credit_q[i]), returned[i], sent[i],
                                                  FREESPACE_UPDATE_SIZE, CREDIT_MAX));
            if (cfg_wr && (cfg_port == NUM_PORT_BITS'(i))) begin
                cfg_d[i]    = 1'b1;
                leaf_d[i]   = cfg_leaf;
                dport_d[i]  = cfg_dport;
                seq_d[i]    = '0;
                credit_d[i] = CREDIT_BITS'(CREDIT_MAX);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q   <= '0;
            last_q  <= NUM_PORT_BITS'(NUM_OUT_PORTS - 1);
            grant_q <= '0;
            pkt_q   <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                leaf_q[i]   <= '0;
                dport_q[i]  <= '0;
                seq_q[i]    <= '0;
                credit_q[i] <= '0;
            end
        end else begin
            cfg_q   <= cfg_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            pkt_q   <= pkt_d;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                leaf_q[i]   <= leaf_d[i];
                dport_q[i]  <= dport_d[i];
                seq_q[i]    <= seq_d[i];
                credit_q[i] <= credit_d[i];
            end
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Scenario bench for leaf_out_arbiter; expected packets are queued at grant and compared on output.
module tb_leaf_out_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] din_user;
    logic [3:0]   vld_user;
    logic [3:0]   ack_user;
    logic         cfg_wr;
    logic [3:0]   cfg_port;
    logic [4:0]   cfg_leaf;
    logic [3:0]   cfg_dport;
    logic         credit_vld;
    logic [3:0]   credit_port;
    logic [48:0]  dout_pkt;
    logic         out_ready;
    logic [3:0]   grant_port;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [48:0] exp_q[$];
    logic [48:0] exp_v;
    logic [48:0] held;

    always #5 clk = ~clk;

    leaf_out_arbiter dut (
        .clk(clk), .reset(reset), .din_user(din_user), .vld_user(vld_user), .ack_user(ack_user),
        .cfg_wr(cfg_wr), .cfg_port(cfg_port), .cfg_leaf(cfg_leaf), .cfg_dport(cfg_dport),
        .credit_vld(credit_vld), .credit_port(credit_port), .dout_pkt(dout_pkt),
        .out_ready(out_ready), .grant_port(grant_port)
    );

    function automatic logic [31:0] dat(input int p);
        return 32'hC0DE_0000 + 32'(p);
    endfunction

    function automatic logic [48:0] mk_pkt(input logic [4:0] leaf, input logic [3:0] dport,
                                           input logic [6:0] seq, input logic [31:0] data);
        return {1'b1, leaf, dport, seq, data};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; vld_user = '0; cfg_wr = 1'b0; credit_vld = 1'b0; out_ready = 1'b1;
        exp_q.delete();
        tick;
        reset = 1'b0;
    endtask

    task automatic do_cfg(input logic [3:0] p, input logic [4:0] leaf, input logic [3:0] dport);
        cfg_wr = 1'b1; cfg_port = p; cfg_leaf = leaf; cfg_dport = dport;
        tick;
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        tests_run++;
        if (dout_pkt !== '0 || ack_user !== '0 || grant_port !== '0) begin
            tests_failed++;
            $display("FAIL reset_during: dout=%h ack=%b grant=%0d, required all zero", dout_pkt, ack_user, grant_port);
        end
        tick; tick;
        reset = 1'b0;
        vld_user = 4'hF;
        #1;
        tests_run++;
        if (ack_user !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_unconfigured_ack: got %b required 0000", ack_user);
        end
        tick;
        tests_run++;
        if (dout_pkt !== '0 || grant_port !== '0) begin
            tests_failed++;
            $display("FAIL reset_after: dout=%h grant=%0d, required zero", dout_pkt, grant_port);
        end
        vld_user = '0;
    endtask

    task automatic test_basic;
        do_reset;
        do_cfg(4'd0, 5'd3, 4'd2);
        din_user[31:0] = 32'hDEADBEEF;
        vld_user = 4'b0001;
        #1;
        tests_run++;
        if (ack_user !== 4'b0001) begin
            tests_failed++;
            $display("FAIL basic_ack: got %b required 0001", ack_user);
        end
        exp_q.push_back(mk_pkt(5'd3, 4'd2, 7'd0, 32'hDEADBEEF));
        tick;
        vld_user = '0;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (dout_pkt !== exp_v || grant_port !== 4'd0) begin
            tests_failed++;
            $display("FAIL basic_pkt: got %h grant %0d required %h grant 0", dout_pkt, grant_port, exp_v);
        end
        tick;
        tests_run++;
        if (dout_pkt !== '0) begin
            tests_failed++;
            $display("FAIL basic_idle: got %h required 0", dout_pkt);
        end
        din_user[31:0] = dat(0);
    endtask

    task automatic test_round_robin;
        do_reset;
        for (int p = 0; p < 4; p++) do_cfg(4'(p), 5'(p + 1), 4'(p));
        vld_user = 4'hF;
        #1;
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (ack_user !== (4'b0001 << (k % 4))) begin
                tests_failed++;
                $display("FAIL rr_ack k=%0d: got %b required %b", k, ack_user, 4'b0001 << (k % 4));
            end
            exp_q.push_back(mk_pkt(5'(k % 4 + 1), 4'(k % 4), 7'(k / 4), dat(k % 4)));
            tick;
            exp_v = exp_q.pop_front();
            tests_run++;
            if (dout_pkt !== exp_v || grant_port !== 4'(k % 4)) begin
                tests_failed++;
                $display("FAIL rr_pkt k=%0d: got %h grant %0d required %h grant %0d",
                         k, dout_pkt, grant_port, exp_v, k % 4);
            end
        end
        vld_user = '0;
    endtask

    task automatic test_credit;
        do_reset;
        do_cfg(4'd1, 5'd5, 4'd7);
        vld_user = 4'b0010;
        #1;
        for (int k = 0; k < 255; k++) begin
            tests_run++;
            if (ack_user !== 4'b0010) begin
                tests_failed++;
                $display("FAIL credit_ack k=%0d: got %b required 0010", k, ack_user);
            end
            exp_q.push_back(mk_pkt(5'd5, 4'd7, 7'(k % 128), dat(1)));
            tick;
            exp_v = exp_q.pop_front();
            tests_run++;
            if (dout_pkt !== exp_v) begin
                tests_failed++;
                $display("FAIL credit_pkt k=%0d: got %h required %h", k, dout_pkt, exp_v);
            end
        end
        tests_run++;
        if (ack_user !== 4'b0000) begin
            tests_failed++;
            $display("FAIL credit_exhausted_ack: got %b required 0000", ack_user);
        end
        credit_vld = 1'b1; credit_port = 4'd1;
        tick;
        credit_vld = 1'b0;
        tests_run++;
        if (dout_pkt !== '0) begin
            tests_failed++;
            $display("FAIL credit_exhausted_idle: got %h required 0", dout_pkt);
        end
        for (int k = 0; k < 64; k++) begin
            tests_run++;
            if (ack_user !== 4'b0010) begin
                tests_failed++;
                $display("FAIL credit_resume_ack k=%0d: got %b required 0010", k, ack_user);
            end
            exp_q.push_back(mk_pkt(5'd5, 4'd7, 7'((255 + k) % 128), dat(1)));
            tick;
            exp_v = exp_q.pop_front();
            tests_run++;
            if (dout_pkt !== exp_v) begin
                tests_failed++;
                $display("FAIL credit_resume_pkt k=%0d: got %h required %h", k, dout_pkt, exp_v);
            end
        end
        tests_run++;
        if (ack_user !== 4'b0000) begin
            tests_failed++;
            $display("FAIL credit_refill_limit: got %b required 0000 after 64 sends", ack_user);
        end
        vld_user = '0;
    endtask

    task automatic test_backpressure;
        do_reset;
        do_cfg(4'd0, 5'd4, 4'd1);
        do_cfg(4'd2, 5'd6, 4'd3);
        vld_user = 4'b0101;
        #1;
        tests_run++;
        if (ack_user !== 4'b0001) begin
            tests_failed++;
            $display("FAIL bp_first_ack: got %b required 0001", ack_user);
        end
        exp_q.push_back(mk_pkt(5'd4, 4'd1, 7'd0, dat(0)));
        tick;
        held = exp_q.pop_front();
        out_ready = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
            tests_run++;
            if (dout_pkt !== held || ack_user !== 4'b0000 || grant_port !== 4'd0) begin
                tests_failed++;
                $display("FAIL bp_hold s=%0d: got %h ack %b grant %0d required %h ack 0000 grant 0",
                         s, dout_pkt, ack_user, grant_port, held);
            end
            if (s == 2) begin
                cfg_wr = 1'b1; cfg_port = 4'd0; cfg_leaf = 5'd9; cfg_dport = 4'd5;
            end
            tick;
            cfg_wr = 1'b0;
        end
        tests_run++;
        if (dout_pkt !== held) begin
            tests_failed++;
            $display("FAIL bp_cfg_held: got %h required %h", dout_pkt, held);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (ack_user !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_release_ack: got %b required 0100", ack_user);
        end
        exp_q.push_back(mk_pkt(5'd6, 4'd3, 7'd0, dat(2)));
        tick;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (dout_pkt !== exp_v || grant_port !== 4'd2) begin
            tests_failed++;
            $display("FAIL bp_release_pkt: got %h grant %0d required %h grant 2", dout_pkt, grant_port, exp_v);
        end
        exp_q.push_back(mk_pkt(5'd9, 4'd5, 7'd0, dat(0)));
        tick;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (dout_pkt !== exp_v) begin
            tests_failed++;
            $display("FAIL bp_reconfig_pkt: got %h required %h", dout_pkt, exp_v);
        end
        vld_user = '0;
    endtask

    task automatic test_seq_wrap;
        int  n;
        logic got;
        do_reset;
        do_cfg(4'd2, 5'd17, 4'd9);
        vld_user = 4'b0100;
        #1;
        for (int k = 0; k < 129; k++) begin
            exp_q.push_back(mk_pkt(5'd17, 4'd9, 7'(k % 128), dat(2)));
            tick;
            exp_v = exp_q.pop_front();
            tests_run++;
            if (dout_pkt !== exp_v) begin
                tests_failed++;
                $display("FAIL seq_wrap k=%0d: got %h required %h", k, dout_pkt, exp_v);
            end
        end
        vld_user = '0;
        do_cfg(4'd2, 5'd17, 4'd9);
        vld_user = 4'b0100;
        credit_vld = 1'b1; credit_port = 4'd2;
        #1;
        n = 0;
        for (int c = 0; c < 400; c++) begin
            got = (ack_user === 4'b0100);
            if (got) begin
                exp_q.push_back(mk_pkt(5'd17, 4'd9, 7'(n % 128), dat(2)));
                n++;
            end
            tick;
            credit_vld = 1'b0;
            if (!got) break;
            exp_v = exp_q.pop_front();
            tests_run++;
            if (dout_pkt !== exp_v) begin
                tests_failed++;
                $display("FAIL sat_pkt n=%0d: got %h required %h", n, dout_pkt, exp_v);
            end
        end
        tests_run++;
        if (n != 256) begin
            tests_failed++;
            $display("FAIL sat_grant_count: got %0d required 256", n);
        end
        vld_user = '0;
    endtask

    task automatic test_reset_midop;
        do_reset;
        do_cfg(4'd0, 5'd1, 4'd1);
        do_cfg(4'd1, 5'd2, 4'd2);
        out_ready = 1'b0;
        vld_user = 4'b0011;
        #1;
        exp_q.push_back(mk_pkt(5'd1, 4'd1, 7'd0, dat(0)));
        tick;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (dout_pkt !== exp_v) begin
            tests_failed++;
            $display("FAIL midop_full: got %h required %h", dout_pkt, exp_v);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (dout_pkt !== '0 || grant_port !== '0 || ack_user !== '0) begin
            tests_failed++;
            $display("FAIL midop_async: dout=%h grant=%0d ack=%b, required all zero", dout_pkt, grant_port, ack_user);
        end
        tick;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            tests_run++;
            if (ack_user !== '0 || dout_pkt !== '0) begin
                tests_failed++;
                $display("FAIL midop_unconfigured c=%0d: ack %b dout %h, required 0", c, ack_user, dout_pkt);
            end
        end
        do_cfg(4'd1, 5'd7, 4'd7);
        tests_run++;
        if (ack_user !== 4'b0010) begin
            tests_failed++;
            $display("FAIL midop_reconfig_ack: got %b required 0010", ack_user);
        end
        exp_q.push_back(mk_pkt(5'd7, 4'd7, 7'd0, dat(1)));
        tick;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (dout_pkt !== exp_v) begin
            tests_failed++;
            $display("FAIL midop_reconfig_pkt: got %h required %h", dout_pkt, exp_v);
        end
        vld_user = '0;
    endtask

    initial begin
        reset = 1'b1; vld_user = '0; cfg_wr = 1'b0; cfg_port = '0; cfg_leaf = '0; cfg_dport = '0;
        credit_vld = 1'b0; credit_port = '0; out_ready = 1'b1;
        din_user = {dat(3), dat(2), dat(1), dat(0)};
        test_reset;
        test_basic;
        test_round_robin;
        test_credit;
        test_backpressure;
        test_seq_wrap;
        test_reset_midop;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
